// File: rtl/joy_debounce.sv
// Joystick debouncer for the two MCP23S17 joystick ports.
// Raw 8-bit ports are synchronised, sampled on a slow prescaler tick and
// accepted only after STABLE_TICKS consecutive disagreeing samples. Outputs
// are active-low (idle 8'hFF) and forced idle while the reader is not ready.
// Optional autofire on fire1 (bit 4) is built when JOY_AUTOFIRE_EN is defined.
module joy_debounce #(
  parameter int unsigned TICK_DIV      = 28000,
  parameter int unsigned TICK_W        = 15,
  parameter int unsigned STABLE_TICKS  = 4
`ifdef JOY_AUTOFIRE_EN
  ,
  parameter int unsigned AF_HALF_TICKS = 50
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ready,
  input  logic [7:0] joya_raw,
  input  logic [7:0] joyb_raw,
`ifdef JOY_AUTOFIRE_EN
  input  logic [1:0] af_enable,
`endif
  output logic [7:0] joya,
  output logic [7:0] joyb,
  output logic       changed,
  output logic       valid
);

  localparam int unsigned NumBits = 16;
  localparam logic [TICK_W-1:0] TickLast = TICK_W'(TICK_DIV - 1);
  localparam logic [3:0] StableLast = 4'(STABLE_TICKS - 1);

  // Bits [7:0] are joystick 1, [15:8] joystick 2.
  logic [NumBits-1:0] sync1_q, sync2_q;
  logic [TICK_W-1:0]  presc_q, presc_d;
  logic               tick;
  logic [3:0]         cnt_q [NumBits];
  logic [3:0]         cnt_d [NumBits];
  logic [NumBits-1:0] deb_q, deb_d;
  logic [NumBits-1:0] out_q, out_d;
  logic [3:0]         vcnt_q, vcnt_d;
  logic               valid_q, valid_d;
  logic               changed_q, changed_d;

  // Tick only fires while the reader is live; ready=0 overrides a coincident tick.
  assign tick = ready && (presc_q == TickLast);

  // Prescaler next state: free-runs while ready, held at zero otherwise.
  always_comb begin
    presc_d = presc_q;
    if (!ready) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + TICK_W'(1);
    end
  end

  // Per-bit debounce: count consecutive disagreeing ticks, accept at STABLE_TICKS.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NumBits; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (!ready) begin
      deb_d = '1;
      for (int i = 0; i < NumBits; i++) begin
        cnt_d[i] = '0;
      end
    end else if (tick) begin
      for (int i = 0; i < NumBits; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == StableLast) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Valid rises once STABLE_TICKS ticks have elapsed since ready went high.
  always_comb begin
    vcnt_d  = vcnt_q;
    valid_d = valid_q;
    if (!ready) begin
      vcnt_d  = '0;
      valid_d = 1'b0;
    end else if (tick && !valid_q) begin
      if (vcnt_q == StableLast) begin
        vcnt_d  = '0;
        valid_d = 1'b1;
      end else begin
        vcnt_d = vcnt_q + 4'd1;
      end
    end
  end

`ifdef JOY_AUTOFIRE_EN
  localparam int unsigned AfW = (AF_HALF_TICKS > 1) ? $clog2(AF_HALF_TICKS) : 1;
  localparam logic [AfW-1:0] AfLast = AfW'(AF_HALF_TICKS - 1);

  logic [AfW-1:0] af_cnt_q [2];
  logic [AfW-1:0] af_cnt_d [2];

  // Output stage: fire1 toggles while held with autofire on, else follows debounce.
  always_comb begin
    out_d = deb_d;
    for (int p = 0; p < 2; p++) begin
      af_cnt_d[p] = '0;
      if (af_enable[p] && !deb_d[8*p+4]) begin
        if (deb_q[8*p+4]) begin
          // Accept cycle: start low with a fresh half-period.
          out_d[8*p+4] = 1'b0;
        end else begin
          out_d[8*p+4] = out_q[8*p+4];
          af_cnt_d[p]  = af_cnt_q[p];
          if (tick) begin
            if (af_cnt_q[p] == AfLast) begin
              out_d[8*p+4] = ~out_q[8*p+4];
              af_cnt_d[p]  = '0;
            end else begin
              af_cnt_d[p] = af_cnt_q[p] + AfW'(1);
            end
          end
        end
      end
    end
  end

  // Autofire half-period counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_cnt_q[0] <= '0;
      af_cnt_q[1] <= '0;
    end else begin
      af_cnt_q[0] <= af_cnt_d[0];
      af_cnt_q[1] <= af_cnt_d[1];
    end
  end
`else
  // Output stage: plain debounced bits.
  always_comb begin
    out_d = deb_d;
  end
`endif

  assign changed_d = (out_d != out_q);

  // State registers: synchroniser, prescaler, debounce counters, outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      presc_q   <= '0;
      for (int i = 0; i < NumBits; i++) begin
        cnt_q[i] <= '0;
      end
      deb_q     <= '1;
      out_q     <= '1;
      vcnt_q    <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= {joyb_raw, joya_raw};
      sync2_q   <= sync1_q;
      presc_q   <= presc_d;
      for (int i = 0; i < NumBits; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      deb_q     <= deb_d;
      out_q     <= out_d;
      vcnt_q    <= vcnt_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
    end
  end

  assign joya    = out_q[7:0];
  assign joyb    = out_q[15:8];
  assign changed = changed_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_joy_debounce.sv
// Self-checking bench for joy_debounce (TICK_DIV=4, STABLE_TICKS=3).
module tb_joy_debounce;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned Stable  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] joya_raw = 8'hFF;
  logic [7:0] joyb_raw = 8'hFF;
  logic [7:0] joya, joyb;
  logic       changed, valid;

  joy_debounce #(
    .TICK_DIV    (TickDiv),
    .TICK_W      (3),
    .STABLE_TICKS(Stable)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ready   (ready),
    .joya_raw(joya_raw),
    .joyb_raw(joyb_raw),
`ifdef JOY_AUTOFIRE_EN
    .af_enable(2'b00),
`endif
    .joya    (joya),
    .joyb    (joyb),
    .changed (changed),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  // Reference model: tick samples of the 2-cycle-delayed raw inputs are kept in
  // a short history; a bit flips when the last Stable samples all disagree with it.
  logic [15:0] m_s1, m_s2, m_out;
  logic        m_valid, m_changed;
  int          m_pc, m_ticks;
  logic [15:0] hist [$];

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_out = '1;
    m_valid = 1'b0; m_changed = 1'b0;
    m_pc = 0; m_ticks = 0;
    hist.delete();
  endtask

  task automatic model_edge(input logic rdy, input logic [15:0] raw);
    logic [15:0] nxt;
    logic        all_diff;
    nxt = m_out;
    if (!rdy) begin
      nxt = '1; m_pc = 0; m_ticks = 0; m_valid = 1'b0;
      hist.delete();
    end else if (m_pc == TickDiv - 1) begin
      m_pc = 0;
      hist.push_back(m_s2);
      if (hist.size() > Stable) void'(hist.pop_front());
      if (hist.size() == Stable) begin
        for (int b = 0; b < 16; b++) begin
          all_diff = 1'b1;
          foreach (hist[k]) if (hist[k][b] == m_out[b]) all_diff = 1'b0;
          if (all_diff) nxt[b] = m_s2[b];
        end
      end
      if (m_ticks < Stable) m_ticks++;
      if (m_ticks >= Stable) m_valid = 1'b1;
    end else begin
      m_pc++;
    end
    m_changed = (nxt != m_out);
    m_out = nxt;
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance model with the inputs seen at the edge, compare 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge(ready, {joyb_raw, joya_raw});
    #1;
    chk("joya_vs_model", {24'd0, joya}, {24'd0, m_out[7:0]});
    chk("joyb_vs_model", {24'd0, joyb}, {24'd0, m_out[15:8]});
    chk("changed_vs_model", {31'd0, changed}, {31'd0, m_changed});
    chk("valid_vs_model", {31'd0, valid}, {31'd0, m_valid});
    if (changed) pulse_cnt++;
  endtask

  typedef struct {
    logic       rdy;
    logic [7:0] a;
    logic [7:0] b;
    int         cyc;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       ev;
    int         epulses;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0] = '{1'b0, 8'hFE, 8'hFF,  6, 8'hFF, 8'hFF, 1'b0, 0}; // ignored while not ready
    vecs[1] = '{1'b1, 8'hFF, 8'hFF, 16, 8'hFF, 8'hFF, 1'b1, 0}; // valid after 3 ticks
    vecs[2] = '{1'b1, 8'hFE, 8'hFF, 16, 8'hFE, 8'hFF, 1'b1, 1}; // clean press
    vecs[3] = '{1'b1, 8'hFE, 8'hFB,  8, 8'hFE, 8'hFF, 1'b1, 0}; // 2-tick glitch
    vecs[4] = '{1'b1, 8'hFE, 8'hFF, 12, 8'hFE, 8'hFF, 1'b1, 0}; // glitch rejected
    vecs[5] = '{1'b1, 8'hEE, 8'h7F, 16, 8'hEE, 8'h7F, 1'b1, 1}; // simultaneous, one pulse
    vecs[6] = '{1'b0, 8'hEE, 8'h7F,  1, 8'hFF, 8'hFF, 1'b0, 1}; // ready drop
    vecs[7] = '{1'b1, 8'hEE, 8'h7F,  8, 8'hFF, 8'hFF, 1'b0, 0}; // only 2 ticks since rise
    vecs[8] = '{1'b1, 8'hEE, 8'h7F,  8, 8'hEE, 8'h7F, 1'b1, 1}; // third tick accepts

    model_reset();
    #12;
    chk("reset_joya", {24'd0, joya}, 32'hFF);
    chk("reset_joyb", {24'd0, joyb}, 32'hFF);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_changed", {31'd0, changed}, 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      ready = vecs[v].rdy;
      joya_raw = vecs[v].a;
      joyb_raw = vecs[v].b;
      pulse_cnt = 0;
      for (int c = 0; c < vecs[v].cyc; c++) step();
      chk($sformatf("vec%0d_joya", v), {24'd0, joya}, {24'd0, vecs[v].ea});
      chk($sformatf("vec%0d_joyb", v), {24'd0, joyb}, {24'd0, vecs[v].eb});
      chk($sformatf("vec%0d_valid", v), {31'd0, valid}, {31'd0, vecs[v].ev});
      chk($sformatf("vec%0d_pulses", v), pulse_cnt, vecs[v].epulses);
    end

    // Edge latency must fall within 2+(S-1)*D+1 .. 2+S*D cycles.
    joya_raw = 8'hFE;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (joya == 8'hFE) begin
        lat = c;
        break;
      end
    end
    chk("press_latency_window", {31'd0, (lat >= 11 && lat <= 14)}, 32'd1);
    for (int c = 0; c < 4; c++) step();

    // Ready drop: immediate idle outputs, one pulse, raw ignored afterwards.
    ready = 1'b0;
    pulse_cnt = 0;
    step();
    chk("drop_joya", {24'd0, joya}, 32'hFF);
    chk("drop_joyb", {24'd0, joyb}, 32'hFF);
    chk("drop_valid", {31'd0, valid}, 32'd0);
    chk("drop_changed", {31'd0, changed}, 32'd1);
    for (int c = 0; c < 12; c++) begin
      joya_raw = 8'($urandom);
      joyb_raw = 8'($urandom);
      step();
    end
    chk("drop_pulses", pulse_cnt, 1);
    chk("drop_hold_joya", {24'd0, joya}, 32'hFF);
    ready = 1'b1;
    joya_raw = 8'hFE;
    joyb_raw = 8'hFF;
    for (int c = 0; c < 20; c++) step();
    chk("rearm_joya", {24'd0, joya}, 32'hFE);
    chk("rearm_valid", {31'd0, valid}, 32'd1);

    // Mid-run asynchronous reset, checked between clock edges.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_joya", {24'd0, joya}, 32'hFF);
    chk("async_reset_valid", {31'd0, valid}, 32'd0);
    chk("async_reset_changed", {31'd0, changed}, 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) step();
    chk("post_reset_joya", {24'd0, joya}, 32'hFE);

    // Randomised phase against the model.
    for (int c = 0; c < 3000; c++) begin
      if (ready) begin
        if ($urandom_range(0, 99) < 2) ready = 1'b0;
      end else begin
        if ($urandom_range(0, 9) == 0) ready = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) joya_raw = joya_raw ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) joyb_raw = joyb_raw ^ 8'(1 << $urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
